// File: rtl/riscv_pipe_pkg.sv
// Shared types and constants for the 5-stage RISC-V pipeline control logic.
package riscv_pipe_pkg;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EX  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_WB  = 2'd3
  } fwd_sel_t;

  typedef enum logic {
    HZ_RUN   = 1'b0,
    HZ_FLUSH = 1'b1
  } hz_state_t;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Priority forwarding select for one decode operand: EX > MEM > WB > register file.
module hazard_fwd_sel
  import riscv_pipe_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs,
  input  logic              use_rs,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_regwen,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_regwen,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_regwen,
  output fwd_sel_t          sel
);

  // A load result does not exist in EX yet, so EX only forwards non-loads; x0 is never forwarded.
  always_comb begin
    sel = FWD_RF;
    if (use_rs && (rs != '0)) begin
      if (ex_regwen && !ex_is_load && (ex_rd == rs)) begin
        sel = FWD_EX;
      end else if (mem_regwen && (mem_rd == rs)) begin
        sel = FWD_MEM;
      end else if (wb_regwen && (wb_rd == rs)) begin
        sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Pipeline sequencer: load-use stalls, redirect flushes, forwarding selects and perf counters.
module pipeline_hazard_controller
  import riscv_pipe_pkg::*;
#(
  parameter int REG_AW       = 5,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_regwen,
  input  logic              ex_is_load,
  input  logic              ex_pc_sel,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_regwen,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_regwen,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              if_id_flush,
  output logic              id_ex_bubble,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              busy_flush,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
);

  hz_state_t  state, next_state;
  logic [2:0] flush_left, next_left;
  logic       load_use, stall_inc, flush_inc;
  fwd_sel_t   sel_a, sel_b;

  hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .rs(id_rs1), .use_rs(id_use_rs1),
    .ex_rd(ex_rd), .ex_regwen(ex_regwen), .ex_is_load(ex_is_load),
    .mem_rd(mem_rd), .mem_regwen(mem_regwen),
    .wb_rd(wb_rd), .wb_regwen(wb_regwen),
    .sel(sel_a)
  );

  hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .rs(id_rs2), .use_rs(id_use_rs2),
    .ex_rd(ex_rd), .ex_regwen(ex_regwen), .ex_is_load(ex_is_load),
    .mem_rd(mem_rd), .mem_regwen(mem_regwen),
    .wb_rd(wb_rd), .wb_regwen(wb_regwen),
    .sel(sel_b)
  );

  assign fwd_a      = reset ? 2'd0 : 2'(sel_a);
  assign fwd_b      = reset ? 2'd0 : 2'(sel_b);
  assign busy_flush = (state == HZ_FLUSH);

  assign load_use = ex_is_load && ex_regwen && (ex_rd != '0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));

  // Outputs are forced to their idle values while reset is held, whatever the inputs do.
  always_comb begin
    next_state   = state;
    next_left    = flush_left;
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    if (!reset) begin
      case (state)
        HZ_RUN: begin
          if (ex_pc_sel) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            flush_inc    = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              next_state = HZ_FLUSH;
              next_left  = 3'(FLUSH_CYCLES - 1);
            end
          end else if (load_use) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_bubble = 1'b1;
            stall_inc    = 1'b1;
          end
        end
        HZ_FLUSH: begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
          next_left    = flush_left - 3'd1;
          if (flush_left == 3'd1) begin
            next_state = HZ_RUN;
            next_left  = 3'd0;
          end
        end
        default: begin
          next_state = HZ_RUN;
          next_left  = 3'd0;
        end
      endcase
    end
  end

  // Performance counters stick at all-ones rather than wrapping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= HZ_RUN;
      flush_left  <= 3'd0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      state      <= next_state;
      flush_left <= next_left;
      if (stall_inc && (stall_count != '1)) stall_count <= stall_count + CNT_W'(1);
      if (flush_inc && (flush_count != '1)) flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench for pipeline_hazard_controller: forwarding table, stalls, flushes, reset, saturation.
module tb_pipeline_hazard_controller;

  typedef struct {
    logic [4:0] id_rs1, id_rs2;
    logic       id_use_rs1, id_use_rs2;
    logic [4:0] ex_rd;
    logic       ex_regwen, ex_is_load, ex_pc_sel;
    logic [4:0] mem_rd;
    logic       mem_regwen;
    logic [4:0] wb_rd;
    logic       wb_regwen;
  } in_t;

  typedef struct {
    int pc_en, if_id_en, if_id_flush, id_ex_bubble;
    int fwd_a, fwd_b, busy_flush, stall_count, flush_count;
  } exp_t;

  typedef struct {
    in_t  i;
    exp_t e;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  id_rs1 = '0, id_rs2 = '0, ex_rd = '0, mem_rd = '0, wb_rd = '0;
  logic        id_use_rs1 = 0, id_use_rs2 = 0, ex_regwen = 0, ex_is_load = 0;
  logic        ex_pc_sel = 0, mem_regwen = 0, wb_regwen = 0;
  logic        pc_en, if_id_en, if_id_flush, id_ex_bubble, busy_flush;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_count, flush_count;
  logic        s_pc_en, s_if_id_en, s_if_id_flush, s_id_ex_bubble, s_busy_flush;
  logic [1:0]  s_fwd_a, s_fwd_b;
  logic [3:0]  s_stall_count, s_flush_count;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];
  vec_t table_v[9];

  always #5 clock = ~clock;

  pipeline_hazard_controller dut (
    .clock(clock), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_regwen(ex_regwen), .ex_is_load(ex_is_load), .ex_pc_sel(ex_pc_sel),
    .mem_rd(mem_rd), .mem_regwen(mem_regwen), .wb_rd(wb_rd), .wb_regwen(wb_regwen),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .busy_flush(busy_flush),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  // Narrow-counter copy fed the same stimulus, used to observe saturation.
  pipeline_hazard_controller #(.CNT_W(4)) dut_sat (
    .clock(clock), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_regwen(ex_regwen), .ex_is_load(ex_is_load), .ex_pc_sel(ex_pc_sel),
    .mem_rd(mem_rd), .mem_regwen(mem_regwen), .wb_rd(wb_rd), .wb_regwen(wb_regwen),
    .pc_en(s_pc_en), .if_id_en(s_if_id_en), .if_id_flush(s_if_id_flush),
    .id_ex_bubble(s_id_ex_bubble), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b),
    .busy_flush(s_busy_flush), .stall_count(s_stall_count), .flush_count(s_flush_count)
  );

  function automatic in_t mk_in(int rs1, int rs2, int u1, int u2, int exrd, int exw, int ld,
                                int psel, int memrd, int memw, int wbrd, int wbw);
    in_t r;
    r.id_rs1 = 5'(rs1);   r.id_rs2 = 5'(rs2);
    r.id_use_rs1 = 1'(u1); r.id_use_rs2 = 1'(u2);
    r.ex_rd = 5'(exrd);   r.ex_regwen = 1'(exw); r.ex_is_load = 1'(ld); r.ex_pc_sel = 1'(psel);
    r.mem_rd = 5'(memrd); r.mem_regwen = 1'(memw);
    r.wb_rd = 5'(wbrd);   r.wb_regwen = 1'(wbw);
    return r;
  endfunction

  function automatic exp_t mk_exp(int pe, int ie, int fl, int bb, int fa, int fb,
                                  int bz, int sc, int fc);
    exp_t r;
    r.pc_en = pe; r.if_id_en = ie; r.if_id_flush = fl; r.id_ex_bubble = bb;
    r.fwd_a = fa; r.fwd_b = fb; r.busy_flush = bz; r.stall_count = sc; r.flush_count = fc;
    return r;
  endfunction

  task automatic cmp(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic drive(input in_t i);
    id_rs1 = i.id_rs1; id_rs2 = i.id_rs2;
    id_use_rs1 = i.id_use_rs1; id_use_rs2 = i.id_use_rs2;
    ex_rd = i.ex_rd; ex_regwen = i.ex_regwen; ex_is_load = i.ex_is_load; ex_pc_sel = i.ex_pc_sel;
    mem_rd = i.mem_rd; mem_regwen = i.mem_regwen; wb_rd = i.wb_rd; wb_regwen = i.wb_regwen;
  endtask

  // Drives one cycle of inputs just after the rising edge and queues what the DUT should show.
  task automatic applyStimulus(input in_t i, input exp_t e);
    @(posedge clock);
    #1;
    drive(i);
    sb.push_back(e);
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    int   sat;
    if (sb.size() == 0) begin
      cmp({tag, " scoreboard_empty"}, 0, 1);
      return;
    end
    e = sb.pop_front();
    sat = (e.stall_count > 15) ? 15 : e.stall_count;
    cmp({tag, " pc_en"},        int'(pc_en),        e.pc_en);
    cmp({tag, " if_id_en"},     int'(if_id_en),     e.if_id_en);
    cmp({tag, " if_id_flush"},  int'(if_id_flush),  e.if_id_flush);
    cmp({tag, " id_ex_bubble"}, int'(id_ex_bubble), e.id_ex_bubble);
    cmp({tag, " fwd_a"},        int'(fwd_a),        e.fwd_a);
    cmp({tag, " fwd_b"},        int'(fwd_b),        e.fwd_b);
    cmp({tag, " busy_flush"},   int'(busy_flush),   e.busy_flush);
    cmp({tag, " stall_count"},  int'(stall_count),  e.stall_count);
    cmp({tag, " flush_count"},  int'(flush_count),  e.flush_count);
    cmp({tag, " sat_stall"},    int'(s_stall_count), sat);
  endtask

  task automatic step(input string tag, input in_t i, input exp_t e);
    applyStimulus(i, e);
    @(negedge clock);
    checkOutput(tag);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    in_t quiet, lu, lu_redir;
    quiet    = mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    lu       = mk_in(6, 1, 1, 1, 6, 1, 1, 0, 0, 0, 0, 0);
    lu_redir = mk_in(6, 1, 1, 1, 6, 1, 1, 1, 0, 0, 0, 0);

    //                       rs1 rs2 u1 u2 exrd exw ld ps memrd mw wbrd ww
    table_v[0].i = mk_in(5, 1, 1, 1, 5, 1, 0, 0, 0, 0, 0, 0);
    table_v[0].e = mk_exp(1, 1, 0, 0, 1, 0, 0, 0, 0);
    table_v[1].i = mk_in(5, 1, 1, 1, 3, 1, 0, 0, 5, 1, 0, 0);
    table_v[1].e = mk_exp(1, 1, 0, 0, 2, 0, 0, 0, 0);
    table_v[2].i = mk_in(5, 1, 1, 1, 3, 1, 0, 0, 4, 1, 5, 1);
    table_v[2].e = mk_exp(1, 1, 0, 0, 3, 0, 0, 0, 0);
    table_v[3].i = mk_in(0, 0, 1, 1, 0, 1, 0, 0, 0, 1, 0, 1);
    table_v[3].e = mk_exp(1, 1, 0, 0, 0, 0, 0, 0, 0);
    table_v[4].i = mk_in(5, 5, 1, 1, 5, 1, 0, 0, 5, 1, 5, 1);
    table_v[4].e = mk_exp(1, 1, 0, 0, 1, 1, 0, 0, 0);
    table_v[5].i = mk_in(5, 6, 1, 1, 7, 1, 0, 0, 6, 1, 6, 1);
    table_v[5].e = mk_exp(1, 1, 0, 0, 0, 2, 0, 0, 0);
    table_v[6].i = mk_in(5, 5, 0, 1, 5, 1, 0, 0, 0, 0, 0, 0);
    table_v[6].e = mk_exp(1, 1, 0, 0, 0, 1, 0, 0, 0);
    table_v[7].i = mk_in(5, 2, 1, 1, 5, 0, 0, 0, 5, 1, 0, 0);
    table_v[7].e = mk_exp(1, 1, 0, 0, 2, 0, 0, 0, 0);
    table_v[8].i = mk_in(31, 31, 1, 1, 2, 1, 0, 0, 3, 1, 31, 1);
    table_v[8].e = mk_exp(1, 1, 0, 0, 3, 3, 0, 0, 0);

    drive(quiet);
    #2;
    cmp("reset pc_en", int'(pc_en), 1);
    cmp("reset busy_flush", int'(busy_flush), 0);
    cmp("reset stall_count", int'(stall_count), 0);
    cmp("reset flush_count", int'(flush_count), 0);
    @(negedge clock);
    reset = 1'b0;

    foreach (table_v[k]) step($sformatf("fwd[%0d]", k), table_v[k].i, table_v[k].e);

    // Load-use: one stall cycle, then the load forwards from MEM.
    step("lu_stall", lu, mk_exp(0, 0, 0, 1, 0, 0, 0, 0, 0));
    step("lu_after", mk_in(6, 1, 1, 1, 0, 0, 0, 0, 6, 1, 0, 0), mk_exp(1, 1, 0, 0, 2, 0, 0, 1, 0));

    // Redirect; a second redirect and a load-use during FLUSH are ignored.
    step("redir_n",   mk_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), mk_exp(1, 1, 1, 1, 0, 0, 0, 1, 0));
    step("redir_n1",  lu_redir, mk_exp(1, 1, 1, 1, 0, 0, 1, 1, 1));
    step("redir_n2",  quiet, mk_exp(1, 1, 0, 0, 0, 0, 0, 1, 1));

    // Redirect and load-use together: redirect wins, no stall counted.
    step("simul",     lu_redir, mk_exp(1, 1, 1, 1, 0, 0, 0, 1, 1));
    step("simul_fl",  quiet, mk_exp(1, 1, 1, 1, 0, 0, 1, 1, 2));
    step("simul_run", quiet, mk_exp(1, 1, 0, 0, 0, 0, 0, 1, 2));

    // Async reset asserted between edges while in FLUSH.
    step("pre_rst",   mk_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), mk_exp(1, 1, 1, 1, 0, 0, 0, 1, 2));
    @(posedge clock);
    #1;
    drive(quiet);
    #2;
    cmp("mid_flush busy_flush", int'(busy_flush), 1);
    reset = 1'b1;
    drive(mk_in(6, 1, 1, 1, 6, 1, 1, 1, 6, 1, 0, 0));
    #1;
    sb.push_back(mk_exp(1, 1, 0, 0, 0, 0, 0, 0, 0));
    checkOutput("in_reset");
    drive(quiet);
    @(negedge clock);
    #1;
    reset = 1'b0;
    step("post_rst",   quiet, mk_exp(1, 1, 0, 0, 0, 0, 0, 0, 0));
    step("post_redir", mk_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), mk_exp(1, 1, 1, 1, 0, 0, 0, 0, 0));
    step("post_flush", quiet, mk_exp(1, 1, 1, 1, 0, 0, 1, 0, 1));
    step("post_run",   quiet, mk_exp(1, 1, 0, 0, 0, 0, 0, 0, 1));

    // Twenty back-to-back load-use stalls: the 4-bit counter sticks at 15.
    for (int k = 0; k < 20; k++) step($sformatf("sat[%0d]", k), lu, mk_exp(0, 0, 0, 1, 0, 0, 0, k, 1));
    step("sat_end", quiet, mk_exp(1, 1, 0, 0, 0, 0, 0, 20, 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
